// File: rtl/operand_fetch_seq_pkg.sv
// matmul_pkg: shared sizes, lane vector types and FSM states for the operand fetch sequencer.
package matmul_pkg;
  localparam int N = 64;
  localparam int LANES = 8;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 12;
  localparam int IDX_W = $clog2(N);
  localparam int BEATS = N / LANES;
  localparam int BEAT_W = $clog2(BEATS);
  typedef logic [LANES-1:0][DATA_W-1:0] lane_vec_t;
  typedef logic [LANES-1:0][ADDR_W-1:0] addr_vec_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;
  typedef struct packed {
    logic last;
    lane_vec_t a;
    lane_vec_t b;
  } beat_t;
  localparam int ENTRY_W = $bits(beat_t);
endpackage

// File: rtl/operand_fetch_seq_if.sv
// operand_fetch_seq_if: control, ROM and MAC-stream signals of the sequencer.
// FETCH_PERF_EN adds the cycle_count/stall_count performance outputs.
interface operand_fetch_seq_if;
  import matmul_pkg::*;
  logic start;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] col_idx;
  addr_vec_t rom_a_addr;
  addr_vec_t rom_b_addr;
  lane_vec_t rom_a_q;
  lane_vec_t rom_b_q;
  logic op_valid;
  logic op_ready;
  lane_vec_t op_a;
  lane_vec_t op_b;
  logic op_last;
  logic busy;
  logic done;
`ifdef FETCH_PERF_EN
  logic [15:0] cycle_count;
  logic [15:0] stall_count;
`endif
  modport master (
    input start, row_idx, col_idx, rom_a_q, rom_b_q, op_ready,
    output rom_a_addr, rom_b_addr, op_valid, op_a, op_b, op_last, busy, done
`ifdef FETCH_PERF_EN
    , output cycle_count, stall_count
`endif
  );
  modport slave (
    output start, row_idx, col_idx, rom_a_q, rom_b_q, op_ready,
    input rom_a_addr, rom_b_addr, op_valid, op_a, op_b, op_last, busy, done
`ifdef FETCH_PERF_EN
    , input cycle_count, stall_count
`endif
  );
endinterface

// File: rtl/operand_fetch_seq_fifo.sv
// op_fifo2: 2-entry FIFO with the head held in its own register for a direct output.
module op_fifo2
  import matmul_pkg::*;
#(
  parameter int W = ENTRY_W
) (
  input  logic         clock,
  input  logic         reset_l,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] head_q, tail_q;
  logic [1:0] count_q;
  logic do_pop, do_push;
  assign do_pop = pop_i && count_q != 2'd0;
  assign do_push = push_i && (count_q != 2'd2 || do_pop);
  always_ff @(posedge clock or negedge reset_l)
    if (!reset_l) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (do_pop) head_q <= (count_q == 2'd2) ? tail_q : din_i;
      else if (do_push && count_q == 2'd0) head_q <= din_i;
      if (do_push && (count_q == 2'd2 || (count_q == 2'd1 && !do_pop))) tail_q <= din_i;
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  assign dout_o = head_q;
  assign full_o = count_q == 2'd2;
  assign empty_o = count_q == 2'd0;
  assign count_o = count_q;
endmodule

// File: rtl/operand_fetch_seq.sv
// operand_fetch_seq: fetches row R of A and column C of B from 1-cycle ROMs and streams LANES-wide beats.
// FETCH_PERF_EN adds busy-cycle and stall-cycle counters.
module operand_fetch_seq
  import matmul_pkg::*;
(
  input logic clock,
  input logic reset_l,
  operand_fetch_seq_if.master bus
);
  fetch_state_t state_q;
  logic [IDX_W-1:0] row_q, col_q;
  logic [BEAT_W-1:0] beat_q;
  logic inflight_q, last_fl_q, busy_q, done_q;
  logic pop, issue, last_beat, full, empty;
  logic [1:0] fifo_cnt;
  beat_t head, din;
  assign pop = !empty && bus.op_ready;
  assign last_beat = beat_q == BEAT_W'(BEATS - 1);
  // A beat popped this cycle frees its slot, which keeps one beat per cycle under full throughput
  assign issue = state_q == FETCH && (pop || !full) &&
                 ({1'b0, fifo_cnt} + {2'b0, inflight_q} < 3'd2 + {2'b0, pop});
  assign din = '{last: last_fl_q, a: bus.rom_a_q, b: bus.rom_b_q};
  op_fifo2 u_fifo (
    .clock  (clock),
    .reset_l(reset_l),
    .push_i (inflight_q),
    .pop_i  (pop),
    .din_i  (din),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty),
    .count_o(fifo_cnt)
  );
  always_comb begin
    bus.rom_a_addr = '0;
    bus.rom_b_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.rom_a_addr[i] = issue ? ADDR_W'(row_q) * ADDR_W'(N) + ADDR_W'(beat_q) * ADDR_W'(LANES) + ADDR_W'(i) : '0;
      bus.rom_b_addr[i] = issue ? (ADDR_W'(beat_q) * ADDR_W'(LANES) + ADDR_W'(i)) * ADDR_W'(N) + ADDR_W'(col_q) : '0;
    end
  end
  always_ff @(posedge clock or negedge reset_l)
    if (!reset_l) begin
      state_q <= IDLE;
      row_q <= '0;
      col_q <= '0;
      beat_q <= '0;
      inflight_q <= 1'b0;
      last_fl_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      last_fl_q <= issue && last_beat;
      beat_q <= issue ? beat_q + 1'b1 : beat_q;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= FETCH;
          row_q <= bus.row_idx;
          col_q <= bus.col_idx;
          beat_q <= '0;
          busy_q <= 1'b1;
        end
        FETCH: if (issue && last_beat) state_q <= DRAIN;
        DRAIN: if (pop && head.last) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.op_valid = !empty;
  assign bus.op_a = head.a;
  assign bus.op_b = head.b;
  assign bus.op_last = !empty && head.last;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
`ifdef FETCH_PERF_EN
  logic [15:0] cycle_q, stall_q;
  always_ff @(posedge clock or negedge reset_l)
    if (!reset_l) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (state_q == IDLE && bus.start) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else begin
      if (busy_q && cycle_q != 16'hFFFF) cycle_q <= cycle_q + 16'd1;
      if (!empty && !bus.op_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  assign bus.cycle_count = cycle_q;
  assign bus.stall_count = stall_q;
`endif
endmodule

// File: tb/tb_operand_fetch_seq.sv
// tb_operand_fetch_seq: randomized checks of operand_fetch_seq against a matrix-level ROM model.
module tb_operand_fetch_seq;
  import matmul_pkg::*;
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;
  operand_fetch_seq_if bus ();
  operand_fetch_seq dut (.clock(clk), .reset_l(rst_l), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  function automatic logic [7:0] rom_a_val(int addr);
    return 8'((addr * 37) ^ (addr >> 5) ^ 8'h3C);
  endfunction
  function automatic logic [7:0] rom_b_val(int addr);
    return 8'((addr * 113 + 17) ^ (addr >> 6));
  endfunction
  function automatic logic [7:0] mat_a(int r, int e);
    return rom_a_val(r * N + e);
  endfunction
  function automatic logic [7:0] mat_b(int e, int c);
    return rom_b_val(e * N + c);
  endfunction
  function automatic lane_vec_t exp_a(int r, int k);
    lane_vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = mat_a(r, k * LANES + i);
    return v;
  endfunction
  function automatic lane_vec_t exp_b(int c, int k);
    lane_vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = mat_b(k * LANES + i, c);
    return v;
  endfunction
  always @(posedge clk)
    for (int i = 0; i < LANES; i++) begin
      bus.rom_a_q[i] <= rom_a_val(int'(bus.rom_a_addr[i]));
      bus.rom_b_q[i] <= rom_b_val(int'(bus.rom_b_addr[i]));
    end
  lane_vec_t got_a[$];
  lane_vec_t got_b[$];
  logic got_last[$];
  int got_t[$];
  int done_t, issues, max_out, unstable;
  bit seen_done;
  addr_vec_t a0_addr, b0_addr;
  logic [ADDR_W-1:0] last_a7, last_b7;
  // mode: 0 ready high, 1 ready 1010..., 2 five-cycle stall on first beat, 3 random ready
  task automatic run_seq(input int r, input int c, input int mode, input int abort_at, input bit inj);
    int t0;
    bit injected;
    logic rdy;
    lane_vec_t hold_a, hold_b;
    got_a.delete();
    got_b.delete();
    got_last.delete();
    got_t.delete();
    seen_done = 0;
    done_t = -1;
    issues = 0;
    max_out = 0;
    unstable = 0;
    t0 = -1;
    injected = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.row_idx = IDX_W'(r);
    bus.col_idx = IDX_W'(c);
    @(negedge clk);
    bus.start = 1'b0;
    a0_addr = bus.rom_a_addr;
    b0_addr = bus.rom_b_addr;
    for (int t = 0; t < 400 && !seen_done; t++) begin
      if (got_a.size() == abort_at) return;
      if (t0 < 0 && bus.op_valid) begin
        t0 = t;
        hold_a = bus.op_a;
        hold_b = bus.op_b;
      end
      rdy = (mode == 0) || (mode == 1 && t % 2 == 0) || (mode == 2 && !(t0 >= 0 && t < t0 + 5)) ||
            (mode == 3 && $urandom_range(0, 1) == 1);
      if (inj && !injected && got_a.size() == 3) begin
        bus.start = 1'b1;
        bus.row_idx = IDX_W'(r ^ 21);
        bus.col_idx = IDX_W'(c ^ 42);
        injected = 1;
      end else bus.start = 1'b0;
      bus.op_ready = rdy;
      #1;
      if (bus.rom_a_addr[1] != '0) begin
        issues++;
        last_a7 = bus.rom_a_addr[7];
        last_b7 = bus.rom_b_addr[7];
      end
      if (mode == 2 && t0 >= 0 && t > t0 && t < t0 + 5 && (bus.op_a !== hold_a || bus.op_b !== hold_b)) unstable++;
      if (bus.op_valid && rdy) begin
        got_a.push_back(bus.op_a);
        got_b.push_back(bus.op_b);
        got_last.push_back(bus.op_last);
        got_t.push_back(t);
      end
      if (issues - got_a.size() > max_out) max_out = issues - got_a.size();
      if (bus.done) begin
        seen_done = 1;
        done_t = t;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.op_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b last=%b, required all 0", bus.op_valid, bus.busy, bus.done, bus.op_last);
    end
    n_checks++;
    if (bus.rom_a_addr !== '0 || bus.rom_b_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_addr: a=%h b=%h, required 0", bus.rom_a_addr, bus.rom_b_addr);
    end
    rst_l = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_basic();
    run_seq(0, 0, 0, -1, 0);
    n_checks++;
    if (!seen_done || got_a.size() != BEATS) begin
      n_fail++;
      $display("FAIL basic_count: done=%0d beats=%0d, required done=1 beats=%0d", seen_done, got_a.size(), BEATS);
    end
    for (int i = 0; i < LANES; i++) begin
      n_checks++;
      if (a0_addr[i] !== ADDR_W'(i) || b0_addr[i] !== ADDR_W'(i * N)) begin
        n_fail++;
        $display("FAIL basic_addr lane %0d: a=%0d b=%0d, required a=%0d b=%0d", i, a0_addr[i], b0_addr[i], i, i * N);
      end
    end
    for (int k = 0; k < got_a.size(); k++) begin
      n_checks++;
      if (got_a[k] !== exp_a(0, k) || got_b[k] !== exp_b(0, k) || got_last[k] !== (k == BEATS - 1) || got_t[k] != k + 2) begin
        n_fail++;
        $display("FAIL basic_beat %0d: a=%h b=%h last=%b t=%0d, required a=%h b=%h last=%b t=%0d",
                 k, got_a[k], got_b[k], got_last[k], got_t[k], exp_a(0, k), exp_b(0, k), k == BEATS - 1, k + 2);
      end
    end
    n_checks++;
    if (done_t != BEATS + 2) begin
      n_fail++;
      $display("FAIL basic_done_time: t=%0d, required %0d", done_t, BEATS + 2);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle_after: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (bus.cycle_count !== 16'd11) begin
      n_fail++;
      $display("FAIL basic_cycle_count: got %0d, required 11", bus.cycle_count);
    end
`endif
  endtask
  task automatic test_corner();
    run_seq(N - 1, N - 1, 0, -1, 0);
    n_checks++;
    if (last_a7 !== 12'd4095 || last_b7 !== 12'd4095) begin
      n_fail++;
      $display("FAIL corner_addr: a=%0d b=%0d, required 4095 4095", last_a7, last_b7);
    end
    n_checks++;
    if (got_a.size() != BEATS || got_a[BEATS-1] !== exp_a(N - 1, BEATS - 1) || got_b[BEATS-1] !== exp_b(N - 1, BEATS - 1)) begin
      n_fail++;
      $display("FAIL corner_data: beats=%0d, required %0d with matching last beat", got_a.size(), BEATS);
    end
  endtask
  task automatic test_backpressure();
    run_seq(5, 9, 2, -1, 0);
    n_checks++;
    if (unstable != 0) begin
      n_fail++;
      $display("FAIL stall_stable: %0d changes while stalled, required 0", unstable);
    end
    n_checks++;
    if (max_out > 2 || issues != BEATS) begin
      n_fail++;
      $display("FAIL stall_credit: max_outstanding=%0d issues=%0d, required <=2 and %0d", max_out, issues, BEATS);
    end
    n_checks++;
    if (got_a.size() != BEATS || !seen_done) begin
      n_fail++;
      $display("FAIL stall_count_beats: beats=%0d done=%0d, required %0d 1", got_a.size(), seen_done, BEATS);
    end
    for (int k = 0; k < got_a.size(); k++) begin
      n_checks++;
      if (got_a[k] !== exp_a(5, k) || got_b[k] !== exp_b(9, k)) begin
        n_fail++;
        $display("FAIL stall_beat %0d: a=%h b=%h, required a=%h b=%h", k, got_a[k], got_b[k], exp_a(5, k), exp_b(9, k));
      end
    end
`ifdef FETCH_PERF_EN
    n_checks++;
    if (bus.stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL stall_counter: got %0d, required 5", bus.stall_count);
    end
`endif
  endtask
  task automatic test_toggle();
    int r, c;
    longint dot_got, dot_ref;
    r = $urandom_range(0, N - 1);
    c = $urandom_range(0, N - 1);
    run_seq(r, c, 1, -1, 0);
    dot_got = 0;
    dot_ref = 0;
    for (int k = 0; k < got_a.size(); k++)
      for (int i = 0; i < LANES; i++) dot_got += longint'(got_a[k][i]) * longint'(got_b[k][i]);
    for (int e = 0; e < N; e++) dot_ref += longint'(mat_a(r, e)) * longint'(mat_b(e, c));
    n_checks++;
    if (got_a.size() != BEATS || dot_got != dot_ref) begin
      n_fail++;
      $display("FAIL toggle_dot R=%0d C=%0d: beats=%0d dot=%0d, required %0d and %0d", r, c, got_a.size(), dot_got, BEATS, dot_ref);
    end
    for (int k = 0; k < got_a.size(); k++) begin
      n_checks++;
      if (got_a[k] !== exp_a(r, k) || got_b[k] !== exp_b(c, k) || got_last[k] !== (k == BEATS - 1)) begin
        n_fail++;
        $display("FAIL toggle_beat %0d: a=%h b=%h last=%b, required a=%h b=%h", k, got_a[k], got_b[k], got_last[k], exp_a(r, k), exp_b(c, k));
      end
    end
  endtask
  task automatic test_restart_ignored();
    run_seq(12, 34, 0, -1, 1);
    n_checks++;
    if (got_a.size() != BEATS || !seen_done) begin
      n_fail++;
      $display("FAIL restart_beats: beats=%0d done=%0d, required %0d 1", got_a.size(), seen_done, BEATS);
    end
    for (int k = 0; k < got_a.size(); k++) begin
      n_checks++;
      if (got_a[k] !== exp_a(12, k) || got_b[k] !== exp_b(34, k)) begin
        n_fail++;
        $display("FAIL restart_beat %0d: a=%h b=%h, required a=%h b=%h", k, got_a[k], got_b[k], exp_a(12, k), exp_b(34, k));
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idle: busy=%b, required 0", bus.busy);
    end
  endtask
  task automatic test_reset_mid();
    int r, c;
    run_seq(7, 3, 0, 4, 0);
    rst_l = 1'b0;
    #1;
    n_checks++;
    if (bus.op_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: valid=%b busy=%b done=%b, required 0 0 0", bus.op_valid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_l = 1'b1;
    r = $urandom_range(0, N - 1);
    c = $urandom_range(0, N - 1);
    run_seq(r, c, 0, -1, 0);
    n_checks++;
    if (got_a.size() != BEATS || !seen_done || got_t[0] != 2) begin
      n_fail++;
      $display("FAIL midreset_rerun: beats=%0d done=%0d, required %0d 1 first at t=2", got_a.size(), seen_done, BEATS);
    end
    for (int k = 0; k < got_a.size(); k++) begin
      n_checks++;
      if (got_a[k] !== exp_a(r, k) || got_b[k] !== exp_b(c, k)) begin
        n_fail++;
        $display("FAIL midreset_beat %0d: a=%h b=%h, required a=%h b=%h", k, got_a[k], got_b[k], exp_a(r, k), exp_b(c, k));
      end
    end
  endtask
  task automatic test_random();
    int r, c;
    for (int n = 0; n < 4; n++) begin
      r = $urandom_range(0, N - 1);
      c = $urandom_range(0, N - 1);
      run_seq(r, c, 3, -1, 0);
      n_checks++;
      if (got_a.size() != BEATS || !seen_done || max_out > 2) begin
        n_fail++;
        $display("FAIL random_run %0d: beats=%0d done=%0d outstanding=%0d", n, got_a.size(), seen_done, max_out);
      end
      for (int k = 0; k < got_a.size(); k++) begin
        n_checks++;
        if (got_a[k] !== exp_a(r, k) || got_b[k] !== exp_b(c, k) || got_last[k] !== (k == BEATS - 1)) begin
          n_fail++;
          $display("FAIL random_beat %0d.%0d: a=%h b=%h, required a=%h b=%h", n, k, got_a[k], got_b[k], exp_a(r, k), exp_b(c, k));
        end
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.row_idx = '0;
    bus.col_idx = '0;
    bus.op_ready = 1'b0;
    test_reset();
    test_basic();
    test_corner();
    test_backpressure();
    test_toggle();
    test_restart_ignored();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
